// File: rtl/invaders_video_pkg.sv
// Shared constants, FSM encoding and the VRAM address helper for the
// Space Invaders video/CPU memory arbiter.
package invaders_video_pkg;

  localparam logic [15:0] VRAM_BASE      = 16'h2400;
  localparam int          BYTES_PER_LINE = 32;
  localparam int          HSYNC_LEN      = 8;
  localparam int          VSYNC_LINES    = 4;
  localparam logic [7:0]  RST1_VECTOR    = 8'hCF;
  localparam logic [7:0]  RST2_VECTOR    = 8'hD7;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PEND = 1'b1
  } irq_state_e;

  // One scanline of bitmap is 32 consecutive bytes, so the line index lands in bits [12:5].
  function automatic logic [15:0] vram_addr(input logic [7:0] line, input logic [4:0] idx);
    return VRAM_BASE + {3'b000, line, 5'b00000} + {11'd0, idx};
  endfunction

endpackage

// File: rtl/invaders_video_timing.sv
// Raster counters, sync pulses, the video fetch slot and the two frame
// interrupt event strobes.
module video_timing
  import invaders_video_pkg::*;
#(
  parameter int LINE_CYCLES  = 128,
  parameter int LINES        = 262,
  parameter int ACTIVE_LINES = 224,
  parameter int MID_LINE     = 96,
  localparam int HW          = $clog2(LINE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_slot,
  output logic [7:0] fetch_line,
  output logic [4:0] fetch_idx,
  output logic       event_mid,
  output logic       event_vbl
);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [8:0]    v_cnt_q, v_cnt_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HW'(LINE_CYCLES - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == 9'(LINES - 1)) ? 9'd0 : v_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign hsync      = (h_cnt_q >= HW'(LINE_CYCLES - HSYNC_LEN));
  assign vsync      = (v_cnt_q >= 9'(LINES - VSYNC_LINES));
  // Video owns every even cycle of the first 64 of an active line.
  assign video_slot = (v_cnt_q < 9'(ACTIVE_LINES)) &&
                      (h_cnt_q < HW'(2 * BYTES_PER_LINE)) && !h_cnt_q[0];
  assign fetch_line = v_cnt_q[7:0];
  assign fetch_idx  = h_cnt_q[5:1];
  assign event_mid  = !rst && (h_cnt_q == '0) && (v_cnt_q == 9'(MID_LINE));
  assign event_vbl  = !rst && (h_cnt_q == '0) && (v_cnt_q == 9'(ACTIVE_LINES));

endmodule

// File: rtl/invaders_video_arbiter.sv
// Single-port RAM arbiter between the i8080 and video scanout, plus the
// mid-screen / vblank RST interrupt scheduler.
module invaders_video_arbiter
  import invaders_video_pkg::*;
#(
  parameter int LINE_CYCLES  = 128,
  parameter int LINES        = 262,
  parameter int ACTIVE_LINES = 224,
  parameter int MID_LINE     = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        vid_valid,
  output logic [7:0]  vid_data,
  output logic [7:0]  vid_line,
  output logic [4:0]  vid_byte,
  output logic        hsync,
  output logic        vsync,
  output logic        irq,
  output logic [7:0]  irq_vector,
  input  logic        irq_ack
);

  logic       video_slot, slot_owned, event_mid, event_vbl;
  logic [7:0] fetch_line;
  logic [4:0] fetch_idx;

  video_timing #(
    .LINE_CYCLES (LINE_CYCLES),
    .LINES       (LINES),
    .ACTIVE_LINES(ACTIVE_LINES),
    .MID_LINE    (MID_LINE)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .hsync     (hsync),
    .vsync     (vsync),
    .video_slot(video_slot),
    .fetch_line(fetch_line),
    .fetch_idx (fetch_idx),
    .event_mid (event_mid),
    .event_vbl (event_vbl)
  );

  assign slot_owned = video_slot && !rst;
  assign cpu_ready  = cpu_req && !video_slot && !rst;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (slot_owned) begin
      mem_en   = 1'b1;
      mem_addr = vram_addr(fetch_line, fetch_idx);
    end else if (cpu_ready) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Return-path registers: RAM data arrives one cycle after the access was issued.
  logic       vid_valid_q, vid_valid_d;
  logic [7:0] vid_line_q, vid_line_d;
  logic [4:0] vid_byte_q, vid_byte_d;
  logic       rd_pend_q, rd_pend_d;
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    vid_valid_d = slot_owned;
    vid_line_d  = slot_owned ? fetch_line : vid_line_q;
    vid_byte_d  = slot_owned ? fetch_idx  : vid_byte_q;
    rd_pend_d   = cpu_ready && !cpu_we;
    rdata_d     = rd_pend_q ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_valid_q <= 1'b0;
      vid_line_q  <= '0;
      vid_byte_q  <= '0;
      rd_pend_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      vid_valid_q <= vid_valid_d;
      vid_line_q  <= vid_line_d;
      vid_byte_q  <= vid_byte_d;
      rd_pend_q   <= rd_pend_d;
      rdata_q     <= rdata_d;
    end
  end

  assign vid_valid  = vid_valid_q;
  assign vid_data   = vid_valid_q ? mem_rdata : 8'h00;
  assign vid_line   = vid_line_q;
  assign vid_byte   = vid_byte_q;
  assign cpu_rvalid = rd_pend_q;
  // Fresh RAM data is forwarded in the rvalid cycle, then held until the next read.
  assign cpu_rdata  = rd_pend_q ? mem_rdata : rdata_q;

  // Interrupt FSM: a new event always wins over a coincident acknowledge.
  irq_state_e state_q, state_d;
  logic [7:0] irq_vector_q, irq_vector_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IRQ_IDLE;
      irq_vector_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_vector_q <= irq_vector_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_vector_d = irq_vector_q;
    case (state_q)
      IRQ_IDLE: if (event_mid || event_vbl) state_d = IRQ_PEND;
      IRQ_PEND: if (irq_ack && !(event_mid || event_vbl)) state_d = IRQ_IDLE;
    endcase
    if (event_vbl)      irq_vector_d = RST2_VECTOR;
    else if (event_mid) irq_vector_d = RST1_VECTOR;
  end

  always_comb begin
    irq        = (state_q == IRQ_PEND);
    irq_vector = irq_vector_q;
  end

endmodule

// File: tb/tb_invaders_video_arbiter.sv
// Scoreboard bench for invaders_video_arbiter: a RAM model, a raster model and
// queues of expected CPU read data and video fetch results.
module tb_invaders_video_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        irq_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        cpu_ready, cpu_rvalid, mem_en, mem_we, vid_valid;
  logic        hsync, vsync, irq;
  logic [7:0]  cpu_rdata, mem_wdata, vid_data, vid_line, irq_vector;
  logic [15:0] mem_addr;
  logic [4:0]  vid_byte;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  invaders_video_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .vid_valid(vid_valid), .vid_data(vid_data), .vid_line(vid_line), .vid_byte(vid_byte),
    .hsync(hsync), .vsync(vsync),
    .irq(irq), .irq_vector(irq_vector), .irq_ack(irq_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hash(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] * 8'd3) ^ 8'hA5;
  endfunction

  function automatic logic slot_at(input int v, input int h);
    return (v < 224) && (h < 64) && (h % 2 == 0);
  endfunction

  // RAM model with one cycle of read latency.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Raster model tracking where the DUT should be.
  int   h_m = 0;
  int   v_m = 0;
  logic prev_slot_m = 1'b0;
  always @(posedge clk) begin
    prev_slot_m <= !rst && slot_at(v_m, h_m);
    if (rst) begin
      h_m <= 0;
      v_m <= 0;
    end else if (h_m == 127) begin
      h_m <= 0;
      v_m <= (v_m == 261) ? 0 : v_m + 1;
    end else begin
      h_m <= h_m + 1;
    end
  end

  typedef struct packed {
    logic [7:0] line;
    logic [4:0] idx;
    logic [7:0] data;
  } vid_exp_t;

  logic [7:0] rd_q[$];
  vid_exp_t   vid_q[$];

  // Scoreboard: pop on DUT output first, then push what this cycle should produce.
  always @(negedge clk) begin
    if (!rst) begin
      check("vid_valid", vid_valid, prev_slot_m);
      if (vid_valid) begin
        if (vid_q.size() > 0) begin
          vid_exp_t e;
          e = vid_q.pop_front();
          check("vid_line", vid_line, e.line);
          check("vid_byte", vid_byte, e.idx);
          check("vid_data", vid_data, e.data);
        end else begin
          check("vid_sb_underflow", vid_q.size(), 1);
        end
      end
      if (cpu_rvalid) begin
        if (rd_q.size() > 0) check("cpu_rdata", cpu_rdata, rd_q.pop_front());
        else                 check("rd_sb_underflow", rd_q.size(), 1);
      end
      if (slot_at(v_m, h_m)) begin
        logic [15:0] a;
        a = 16'(32'h2400 + v_m * 32 + h_m / 2);
        check("slot_mem_en", mem_en, 1);
        check("slot_mem_we", mem_we, 0);
        check("slot_mem_addr", mem_addr, a);
        check("slot_cpu_ready", cpu_ready, 0);
        vid_q.push_back('{line: 8'(v_m), idx: 5'(h_m / 2), data: hash(a)});
      end
      if (cpu_req && cpu_ready && !cpu_we) rd_q.push_back(hash(cpu_addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int v, input int h);
    int n;
    n = 0;
    while (!(v_m == v && h_m == h) && n < 40000) begin
      step();
      n++;
    end
    if (n >= 40000) check("wait_timeout", v_m * 256 + h_m, v * 256 + h);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 65536; i++) ram[i] = hash(16'(i));

    // Reset held with a pending CPU request.
    rst = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mem_en", mem_en, 0);
      check("rst_cpu_ready", cpu_ready, 0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_vid_valid", vid_valid, 0);
      check("rst_vid_line", vid_line, 0);
      check("rst_irq", irq, 0);
      check("rst_irq_vector", irq_vector, 0);
      check("rst_hsync", hsync, 0);
      check("rst_vsync", vsync, 0);
    end
    rst = 1'b0; cpu_addr = 16'h0100; cpu_we = 1'b0;
    #1;
    check("first_mem_addr", mem_addr, 16'h2400);
    check("first_mem_en", mem_en, 1);
    check("first_cpu_ready", cpu_ready, 0);

    // CPU reads interleaved with video slots on line 0.
    step();
    check("h1_cpu_ready", cpu_ready, 1);
    check("h1_mem_addr", mem_addr, 16'h0100);
    check("h1_mem_we", mem_we, 0);
    step();
    cpu_addr = 16'h0101;
    #1;
    check("h2_cpu_ready", cpu_ready, 0);
    check("h2_mem_addr", mem_addr, 16'h2401);
    check("h2_cpu_rvalid", cpu_rvalid, 1);
    step();
    check("h3_cpu_ready", cpu_ready, 1);
    check("h3_mem_addr", mem_addr, 16'h0101);
    step();
    cpu_req = 1'b0;
    #1;
    check("h4_cpu_rvalid", cpu_rvalid, 1);
    check("h4_cpu_rdata", cpu_rdata, hash(16'h0101));
    step();
    check("h5_cpu_rvalid", cpu_rvalid, 0);
    check("h5_rdata_hold", cpu_rdata, hash(16'h0101));
    check("h5_idle_mem_en", mem_en, 0);

    // Full fetch of line 5.
    wait_pos(5, 0);
    pulses = 0;
    for (int k = 0; k < 128; k++) begin
      if (vid_valid && vid_line == 8'd5) pulses++;
      if (k == 100) check("line5_idle_mem_en", mem_en, 0);
      step();
    end
    check("line5_pulses", pulses, 32);

    // Mid-screen interrupt and acknowledge.
    wait_pos(96, 0);
    check("irq_before_mid", irq, 0);
    step();
    check("irq_mid", irq, 1);
    check("vec_mid", irq_vector, 8'hCF);
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    #1;
    check("irq_after_ack", irq, 0);
    check("vec_after_ack", irq_vector, 8'hCF);

    // Vblank interrupt, left pending into the next frame.
    wait_pos(224, 1);
    check("irq_vbl", irq, 1);
    check("vec_vbl", irq_vector, 8'hD7);

    // CPU writes every cycle of a blanking line; hsync window checked along the way.
    wait_pos(230, 0);
    cpu_req = 1'b1; cpu_we = 1'b1;
    for (int k = 0; k < 128; k++) begin
      cpu_addr  = 16'h4000 + 16'(k);
      cpu_wdata = 8'(k) ^ 8'h3C;
      #1;
      check("blank_cpu_ready", cpu_ready, 1);
      check("blank_mem_we", mem_we, 1);
      check("blank_mem_addr", mem_addr, 16'h4000 + 16'(k));
      check("blank_mem_wdata", mem_wdata, 8'(k) ^ 8'h3C);
      check("hsync", hsync, (k >= 120) ? 1 : 0);
      step();
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    check("blank_idle_mem_en", mem_en, 0);
    check("ram_write", ram[16'h4055], 8'h55 ^ 8'h3C);

    // Vsync window and frame wrap.
    wait_pos(257, 127);
    check("vsync_257", vsync, 0);
    step();
    check("vsync_258", vsync, 1);
    wait_pos(261, 127);
    check("vsync_261", vsync, 1);
    check("hsync_127", hsync, 1);
    step();
    check("wrap_vsync", vsync, 0);
    check("wrap_hsync", hsync, 0);
    check("wrap_mem_addr", mem_addr, 16'h2400);
    check("wrap_mem_en", mem_en, 1);

    // Ack coincident with mid event while still pending: event wins, vector replaced.
    wait_pos(96, 0);
    check("irq_still_pend", irq, 1);
    check("vec_still_d7", irq_vector, 8'hD7);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    #1;
    check("irq_coincident", irq, 1);
    check("vec_coincident", irq_vector, 8'hCF);

    // Unacked RST 1 overwritten by RST 2.
    wait_pos(224, 1);
    check("irq_overwrite", irq, 1);
    check("vec_overwrite", irq_vector, 8'hD7);
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    #1;
    check("irq_final_ack", irq, 0);
    check("vec_final", irq_vector, 8'hD7);

    step();
    check("rd_q_drain", rd_q.size(), 0);
    check("vid_q_drain", vid_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
